sti_pixel_packer: RTL and testbench
===================================

Name: sti_pixel_packer

Overview:
- Sits directly downstream of the serial transmitter stage.
- Consumes the single-bit serial stream (so_valid/so_data), regroups it MSB-first into 8-bit pixels, and writes each pixel into a checkerboard-interleaved two-bank pixel memory.
- When the end-of-stream indication arrives, zero-fills all remaining pixel locations and then signals done.

Parameters:
- DEPTH, 256, total pixel locations; power of two, ≥4.
- IMG_W, 16, pixels per image row; power of two, divides DEPTH.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- so_valid  in  1  serial bit valid, sampled each rising edge.
- so_data  in  1  serial bit.
- pi_end  in  1  end of stream; level, may stay high.
- mem_wr  out  1  one-cycle write strobe.
- mem_bank  out  1  bank select: 0 = even bank, 1 = odd bank.
- mem_addr  out  log2(DEPTH)-1  word address within the selected bank.
- mem_data  out  8  pixel value.
- pix_cnt  out  log2(DEPTH)+1  number of pixels written so far.
- done  out  1  high once all DEPTH locations are written; held until reset.

Behaviour:
- Reset values: mem_wr=0, mem_bank=0, mem_addr=0, mem_data=0, pix_cnt=0, done=0, state=RECV, bit_cnt=0, shift=0. Reset mid-operation aborts at once and discards any partial byte.
- States: RECV, FILL, DONE.
- RECV, normal bit capture:
  - On each edge with so_valid=1 and pi_end=0: shift <= {shift[6:0], so_data}; bit_cnt <= bit_cnt+1 (3-bit, wraps).
  - On the edge where bit_cnt==7 and a bit is captured: register mem_data={shift[6:0],so_data}.
  - On that same edge: mem_wr=1 for exactly the following cycle, with address derived from the current pix_cnt.
  - Also on that edge: pix_cnt increments and bit_cnt returns to 0.
  - Latency: mem_wr is high in the cycle right after the 8th bit's sampling edge.
- Address map, with p = pixel index = pix_cnt before increment:
  - row = p / IMG_W; col = p mod IMG_W.
  - mem_bank = row[0] XOR col[0].
  - mem_addr = p >> 1.
- RECV, end of stream:
  - If pi_end=1 at an edge, any so_valid bit on that edge is ignored.
  - The partial byte is discarded: bit_cnt cleared, shift cleared.
  - Next state is FILL if pix_cnt<DEPTH, else DONE.
- RECV, overflow: the write of pixel DEPTH-1 moves the block to DONE; later bits are ignored.
- FILL:
  - On each edge, write mem_data=0x00 at pixel index pix_cnt, using the same address map. mem_wr stays high on consecutive cycles.
  - pix_cnt increments each write; so_valid and so_data are ignored.
  - After the edge that writes index DEPTH-1, the next state is DONE.
- DONE:
  - mem_wr=0; done=1; pix_cnt=DEPTH.
  - All inputs are ignored until rst.
- Simultaneous events:
  - pi_end has priority over so_valid.
  - If pi_end arrives on the same edge as an 8th bit, that pixel is NOT written.
- mem_data and the address outputs hold their last values while mem_wr=0.

Test Plan:
- Reset hold → all outputs 0, state RECV; assert rst mid-byte after 3 bits → bit_cnt and shift cleared, no write occurs.
- Serial bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles → one mem_wr pulse the cycle after the 8th bit: mem_data=0xA5, mem_bank=0, mem_addr=0, pix_cnt=1.
- Gapped stream: 0xFF sent with so_valid low every other cycle, then 0x01 → second pixel: mem_data=0x01, mem_bank=1, mem_addr=0; with IMG_W=16, pixel 16 gets mem_bank=1 and pixel 17 gets mem_bank=0.
- 3 pixels sent, then 4 further bits, then pi_end=1 → partial byte dropped; 253 consecutive writes of 0x00 for indices 3..255; done=1 the cycle after the last write; pix_cnt=256.
- pi_end asserted on the same edge as an 8th bit → that pixel is not written; FILL starts at the prior pix_cnt.
- 256 full pixels streamed → done=1 with no FILL writes; further so_valid bits and pi_end produce no mem_wr.

Source files
------------

// File: rtl/sti_pixel_packer.sv
// ---------------------------------------------------------------------------
// sti_pixel_packer
//
// Regroups the single-bit serial stream from the transmitter stage into 8-bit
// pixels (MSB first) and writes each one into a two-bank pixel memory whose
// banks are interleaved as a checkerboard. Once the end-of-stream indication
// arrives, the remaining pixel locations are written with zero, and then done
// is raised.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   so_valid  serial bit valid
//   so_data   serial bit
//   pi_end    end of stream (level; may stay high)
//   mem_wr    one-cycle write strobe per pixel
//   mem_bank  0 = even bank, 1 = odd bank
//   mem_addr  word address inside the selected bank (pixel index >> 1)
//   mem_data  pixel value
//   pix_cnt   number of pixels written so far
//   done      high once all DEPTH locations are written; held until rst
// ---------------------------------------------------------------------------
module sti_pixel_packer #(
    parameter int DEPTH = 256,
    parameter int IMG_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       so_valid,
    input  logic                       so_data,
    input  logic                       pi_end,
    output logic                       mem_wr,
    output logic                       mem_bank,
    output logic [$clog2(DEPTH)-2:0]   mem_addr,
    output logic [7:0]                 mem_data,
    output logic [$clog2(DEPTH):0]     pix_cnt,
    output logic                       done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(IMG_W);
    localparam logic [AW:0] LAST_PIX = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    // With one pixel per row the column is always 0, so it never toggles the bank.
    localparam logic        COL_EN   = (IMG_W > 1) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_RECV = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        w_cap;
    logic        w_flush;
    logic        w_pix_wr;
    logic [7:0]  w_wr_data;
    logic        w_bank;

    // Checkerboard bank: row parity XOR column parity. pix_cnt[CW] is row bit 0;
    // it stays valid when IMG_W == DEPTH because pix_cnt[AW] is 0 whenever we write.
    assign w_bank = pix_cnt[CW] ^ (pix_cnt[0] & COL_EN);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RECV;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-edge action decode; pi_end outranks so_valid.
    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        w_flush     = 1'b0;
        w_pix_wr    = 1'b0;
        w_wr_data   = 8'h00;
        case (r_state)
            ST_RECV: begin
                if (pi_end) begin
                    // The partial byte (and any 8th bit on this edge) is dropped.
                    w_flush     = 1'b1;
                    w_state_nxt = (pix_cnt < FULL_CNT) ? ST_FILL : ST_DONE;
                end else if (so_valid) begin
                    w_cap = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_pix_wr  = 1'b1;
                        w_wr_data = {r_shift[6:0], so_data};
                        if (pix_cnt == LAST_PIX) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_RECV;
                        end
                    end else begin
                        w_pix_wr = 1'b0;
                    end
                end else begin
                    w_cap = 1'b0;
                end
            end
            ST_FILL: begin
                w_pix_wr  = 1'b1;
                w_wr_data = 8'h00;
                if (pix_cnt == LAST_PIX) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_RECV;
            end
        endcase
    end

    // Bit assembly, memory write port and progress outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            mem_wr    <= 1'b0;
            mem_bank  <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= 8'h00;
            pix_cnt   <= '0;
            done      <= 1'b0;
        end else begin
            if (w_flush) begin
                r_bit_cnt <= 3'd0;
                r_shift   <= 8'h00;
            end else if (w_cap) begin
                // bit_cnt wraps 7 -> 0 on the pixel-completing bit.
                r_shift   <= {r_shift[6:0], so_data};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end else begin
                r_bit_cnt <= r_bit_cnt;
                r_shift   <= r_shift;
            end

            mem_wr <= w_pix_wr;
            if (w_pix_wr) begin
                mem_data <= w_wr_data;
                mem_bank <= w_bank;
                mem_addr <= pix_cnt[AW-1:1];
                pix_cnt  <= pix_cnt + {{AW{1'b0}}, 1'b1};
            end else begin
                mem_data <= mem_data;
                mem_bank <= mem_bank;
                mem_addr <= mem_addr;
                pix_cnt  <= pix_cnt;
            end

            // done follows one cycle after entering DONE, i.e. after the last write cycle.
            done <= (r_state == ST_DONE);
        end
    end

endmodule

// File: tb/tb_sti_pixel_packer.sv
// ---------------------------------------------------------------------------
// Self-checking bench for sti_pixel_packer. A stream-level reference model
// (pixel counter, partial byte value, end-of-stream flag) predicts every
// cycle's write strobe, address, data, pix_cnt and done.
// ---------------------------------------------------------------------------
module tb_sti_pixel_packer;

    localparam int DEPTH = 256;
    localparam int IMG_W = 16;
    localparam int AW    = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            so_valid;
    logic            so_data;
    logic            pi_end;
    logic            mem_wr;
    logic            mem_bank;
    logic [AW-2:0]   mem_addr;
    logic [7:0]      mem_data;
    logic [AW:0]     pix_cnt;
    logic            done;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int              m_pix;
    int              m_nbits;
    int              m_val;
    bit              m_ended;
    logic            m_wr;
    logic            m_bank;
    logic [AW-2:0]   m_addr;
    logic [7:0]      m_data;
    logic            m_done;

    // Stimulus items: {so_valid, so_data, pi_end}
    logic [2:0]      stim[$];

    always #5 clk = ~clk;

    sti_pixel_packer #(.DEPTH(DEPTH), .IMG_W(IMG_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .so_valid (so_valid),
        .so_data  (so_data),
        .pi_end   (pi_end),
        .mem_wr   (mem_wr),
        .mem_bank (mem_bank),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .pix_cnt  (pix_cnt),
        .done     (done)
    );

    function automatic string obs_s();
        return $sformatf("wr=%b bank=%b addr=%0d data=%h pix=%0d done=%b",
                         mem_wr, mem_bank, mem_addr, mem_data, pix_cnt, done);
    endfunction

    function automatic string exp_s();
        return $sformatf("wr=%b bank=%b addr=%0d data=%h pix=%0d done=%b",
                         m_wr, m_bank, m_addr, m_data, m_pix, m_done);
    endfunction

    task automatic model_reset();
        m_pix = 0; m_nbits = 0; m_val = 0; m_ended = 1'b0;
        m_wr = 1'b0; m_bank = 1'b0; m_addr = '0; m_data = 8'h00; m_done = 1'b0;
    endtask

    task automatic model_write(input int val);
        m_wr   = 1'b1;
        m_bank = (((m_pix / IMG_W) % 2) != (m_pix % 2));
        m_addr = (AW-1)'(m_pix / 2);
        m_data = 8'(val % 256);
        m_pix  = m_pix + 1;
    endtask

    // Drive one cycle of inputs, advance the model, land 1 time unit after the edge.
    task automatic step(input logic v, input logic d, input logic e);
        so_valid = v; so_data = d; pi_end = e;
        m_done = (m_pix == DEPTH);
        m_wr   = 1'b0;
        if (m_pix < DEPTH) begin
            if (m_ended) begin
                model_write(0);
            end else if (e) begin
                m_ended = 1'b1; m_nbits = 0; m_val = 0;
            end else if (v) begin
                m_val   = m_val * 2 + int'(d);
                m_nbits = m_nbits + 1;
                if (m_nbits == 8) begin
                    model_write(m_val);
                    m_nbits = 0; m_val = 0;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        so_valid = 1'b0; so_data = 1'b0; pi_end = 1'b0;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // gap: 0 none, 1 idle cycle after every bit, 2 random idle cycles
    task automatic push_byte(input logic [7:0] val, input int gap);
        for (int i = 7; i >= 0; i--) begin
            stim.push_back({1'b1, val[i], 1'b0});
            if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0))
                stim.push_back({1'b0, 1'($urandom_range(0, 1)), 1'b0});
        end
    endtask

    task automatic test_reset();
        logic [2:0] it;
        so_valid = 1'b0; so_data = 1'b0; pi_end = 1'b0;
        rst = 1'b1;
        model_reset();
        #12;
        n_chk++;
        if ({mem_wr, mem_bank, mem_addr, mem_data, pix_cnt, done} !== {1'b0, 1'b0, 7'd0, 8'h00, 9'd0, 1'b0}) begin
            n_err++; $display("FAIL reset_hold: got %s want all zero", obs_s());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        // three bits of a byte, then an asynchronous reset between edges
        stim.push_back(3'b110); stim.push_back(3'b100); stim.push_back(3'b110);
        while (stim.size() > 0) begin
            it = stim.pop_front();
            step(it[2], it[1], it[0]);
            n_chk++;
            if (mem_wr !== m_wr || pix_cnt !== (AW+1)'(m_pix) || done !== m_done) begin
                n_err++; $display("FAIL reset_partial: got %s want %s", obs_s(), exp_s());
            end
        end
        rst = 1'b1;
        #2;
        n_chk++;
        if (mem_wr !== 1'b0 || pix_cnt !== 9'd0) begin
            n_err++; $display("FAIL reset_midbyte: got %s want wr=0 pix=0", obs_s());
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single_pixel();
        logic [2:0] it;
        push_byte(8'hA5, 0);
        while (stim.size() > 0) begin
            it = stim.pop_front();
            step(it[2], it[1], it[0]);
            n_chk++;
            if (mem_wr !== m_wr || pix_cnt !== (AW+1)'(m_pix) || done !== m_done ||
                (m_wr && {mem_bank, mem_addr, mem_data} !== {m_bank, m_addr, m_data})) begin
                n_err++; $display("FAIL single_pixel: got %s want %s", obs_s(), exp_s());
            end
        end
        n_chk++;
        if ({mem_wr, mem_bank, mem_addr, mem_data, pix_cnt} !== {1'b1, 1'b0, 7'd0, 8'hA5, 9'd1}) begin
            n_err++; $display("FAIL single_pixel_A5: got %s want wr=1 bank=0 addr=0 data=a5 pix=1", obs_s());
        end
        step(1'b0, 1'b0, 1'b0);
        n_chk++;
        if (mem_wr !== 1'b0 || mem_data !== 8'hA5 || pix_cnt !== 9'd1) begin
            n_err++; $display("FAIL single_pulse: got %s want wr=0 data=a5 pix=1", obs_s());
        end
    endtask

    task automatic test_gapped();
        logic [2:0] it;
        do_reset();
        push_byte(8'hFF, 1);
        push_byte(8'h01, 0);
        for (int p = 2; p < 18; p++) push_byte(8'($urandom_range(0, 255)), 2);
        while (stim.size() > 0) begin
            it = stim.pop_front();
            step(it[2], it[1], it[0]);
            n_chk++;
            if (mem_wr !== m_wr || pix_cnt !== (AW+1)'(m_pix) || done !== m_done ||
                (m_wr && {mem_bank, mem_addr, mem_data} !== {m_bank, m_addr, m_data})) begin
                n_err++; $display("FAIL gapped: got %s want %s", obs_s(), exp_s());
            end
            if (m_wr && m_pix == 2) begin
                n_chk++;
                if ({mem_bank, mem_addr, mem_data} !== {1'b1, 7'd0, 8'h01}) begin
                    n_err++; $display("FAIL gapped_pix1: got %s want bank=1 addr=0 data=01", obs_s());
                end
            end
            if (m_wr && (m_pix == 17 || m_pix == 18)) begin
                n_chk++;
                if (mem_bank !== ((m_pix == 17) ? 1'b1 : 1'b0)) begin
                    n_err++; $display("FAIL gapped_row_bank: got %s at pixel %0d", obs_s(), m_pix - 1);
                end
            end
        end
    endtask

    task automatic test_end_fill();
        logic [2:0] it;
        int n_fill;
        do_reset();
        for (int p = 0; p < 3; p++) push_byte(8'($urandom_range(0, 255)), 2);
        for (int b = 0; b < 4; b++) stim.push_back({1'b1, 1'($urandom_range(0, 1)), 1'b0});
        while (stim.size() > 0) begin
            it = stim.pop_front();
            step(it[2], it[1], it[0]);
            n_chk++;
            if (mem_wr !== m_wr || pix_cnt !== (AW+1)'(m_pix) || done !== m_done ||
                (m_wr && {mem_bank, mem_addr, mem_data} !== {m_bank, m_addr, m_data})) begin
                n_err++; $display("FAIL end_fill_stream: got %s want %s", obs_s(), exp_s());
            end
        end
        n_fill = 0;
        for (int c = 0; c < DEPTH + 10; c++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (c < 5) ? 1'b1 : 1'($urandom_range(0, 1)));
            if (mem_wr === 1'b1) n_fill++;
            n_chk++;
            if (mem_wr !== m_wr || pix_cnt !== (AW+1)'(m_pix) || done !== m_done ||
                (m_wr && {mem_bank, mem_addr, mem_data} !== {m_bank, m_addr, m_data})) begin
                n_err++; $display("FAIL end_fill: got %s want %s", obs_s(), exp_s());
            end
            if (done === 1'b1 && m_done) break;
        end
        n_chk++;
        if (n_fill != 253 || done !== 1'b1 || pix_cnt !== 9'd256) begin
            n_err++; $display("FAIL end_fill_total: got fills=%0d done=%b pix=%0d want fills=253 done=1 pix=256",
                              n_fill, done, pix_cnt);
        end
    endtask

    task automatic test_end_on_8th();
        logic [2:0] it;
        bit first;
        do_reset();
        push_byte(8'($urandom_range(0, 255)), 0);
        for (int b = 0; b < 7; b++) stim.push_back({1'b1, 1'($urandom_range(0, 1)), 1'b0});
        stim.push_back({1'b1, 1'($urandom_range(0, 1)), 1'b1});
        while (stim.size() > 0) begin
            it = stim.pop_front();
            step(it[2], it[1], it[0]);
            n_chk++;
            if (mem_wr !== m_wr || pix_cnt !== (AW+1)'(m_pix) || done !== m_done ||
                (m_wr && {mem_bank, mem_addr, mem_data} !== {m_bank, m_addr, m_data})) begin
                n_err++; $display("FAIL end_on_8th: got %s want %s", obs_s(), exp_s());
            end
        end
        first = 1'b1;
        for (int c = 0; c < DEPTH + 10; c++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            n_chk++;
            if (mem_wr !== m_wr || pix_cnt !== (AW+1)'(m_pix) || done !== m_done ||
                (m_wr && {mem_bank, mem_addr, mem_data} !== {m_bank, m_addr, m_data})) begin
                n_err++; $display("FAIL end_on_8th_fill: got %s want %s", obs_s(), exp_s());
            end
            if (first && mem_wr === 1'b1) begin
                first = 1'b0;
                n_chk++;
                if ({mem_bank, mem_addr, mem_data, pix_cnt} !== {1'b1, 7'd0, 8'h00, 9'd2}) begin
                    n_err++; $display("FAIL end_on_8th_first: got %s want bank=1 addr=0 data=00 pix=2", obs_s());
                end
            end
            if (done === 1'b1 && m_done) break;
        end
        n_chk++;
        if (done !== 1'b1 || pix_cnt !== 9'd256) begin
            n_err++; $display("FAIL end_on_8th_done: got %s want done=1 pix=256", obs_s());
        end
    endtask

    task automatic test_full_stream();
        logic [2:0] it;
        int n_wr;
        do_reset();
        for (int p = 0; p < DEPTH; p++) push_byte(8'($urandom_range(0, 255)), 2);
        for (int c = 0; c < 24; c++)
            stim.push_back({1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
        n_wr = 0;
        while (stim.size() > 0) begin
            it = stim.pop_front();
            step(it[2], it[1], it[0]);
            if (mem_wr === 1'b1) n_wr++;
            n_chk++;
            if (mem_wr !== m_wr || pix_cnt !== (AW+1)'(m_pix) || done !== m_done ||
                (m_wr && {mem_bank, mem_addr, mem_data} !== {m_bank, m_addr, m_data})) begin
                n_err++; $display("FAIL full_stream: got %s want %s", obs_s(), exp_s());
            end
        end
        n_chk++;
        if (n_wr != DEPTH || done !== 1'b1 || pix_cnt !== 9'd256 || mem_wr !== 1'b0) begin
            n_err++; $display("FAIL full_stream_total: got writes=%0d %s want writes=256 wr=0 done=1 pix=256",
                              n_wr, obs_s());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_pixel();
        test_gapped();
        test_end_fill();
        test_end_on_8th();
        test_full_stream();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
